// File: rtl/toy_fp_issue_arb.sv
// Round-robin issue arbiter feeding one non-pipelined FP unit through a single output register.
// Optional counters perf_grant_cnt/perf_stall_cnt exist only when TOY_FP_ARB_PERF_EN is defined.
module toy_fp_issue_arb #(
    parameter int NUM_REQ   = 2,
    parameter int PLD_W     = 128,
    parameter int FP_STAGES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_vld,
    input  logic [NUM_REQ*PLD_W-1:0]   req_pld,
    output logic [NUM_REQ-1:0]         req_rdy,
    input  logic                       flush,
    output logic                       fp_vld,
    output logic [PLD_W-1:0]           fp_pld,
    input  logic                       fp_rdy,
    output logic [$clog2(NUM_REQ)-1:0] fp_grant_id,
    output logic                       fp_busy
`ifdef TOY_FP_ARB_PERF_EN
    ,
    output logic [31:0]                perf_grant_cnt,
    output logic [31:0]                perf_stall_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(FP_STAGES + 3);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [PLD_W-1:0]  pld_q, pld_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;

    logic              can_take;
    logic              fire;
    logic              found;
    logic              grant;
    logic [ID_W-1:0]   win;
    int                cand;

    always_comb begin
        // req_rdy is gated by rst_n so it reads 0 for the whole reset pulse.
        can_take = rst_n & ~flush & ((state_q == IDLE) | fp_rdy);
        fire     = (state_q == HOLD) & fp_rdy;
        found    = 1'b0;
        win      = ptr_q;
        cand     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_vld[cand]) begin
                found = 1'b1;
                win   = ID_W'(cand);
            end
        end
        grant   = can_take & found;
        req_rdy = grant ? (NUM_REQ'(1) << win) : '0;

        state_d    = state_q;
        pld_d      = pld_q;
        id_d       = id_q;
        ptr_d      = ptr_q;
        busy_cnt_d = busy_cnt_q;

        if (grant) begin
            pld_d   = req_pld[int'(win)*PLD_W +: PLD_W];
            id_d    = win;
            ptr_d   = win;
            state_d = HOLD;
        end else if (fire || flush) begin
            state_d = IDLE;
        end

        // A flush coinciding with fp_rdy still fires: the wrapper has already taken it.
        if (fire) begin
            busy_cnt_d = CNT_W'(FP_STAGES + 2);
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pld_q      <= '0;
            id_q       <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pld_q      <= pld_d;
            id_q       <= id_d;
            ptr_q      <= ptr_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign fp_vld      = (state_q == HOLD);
    assign fp_pld      = pld_q;
    assign fp_grant_id = id_q;
    assign fp_busy     = (busy_cnt_q != '0);

`ifdef TOY_FP_ARB_PERF_EN
    logic [31:0] grant_cnt_q, grant_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant ? grant_cnt_q + 32'd1 : grant_cnt_q;
        stall_cnt_d = ((state_q == HOLD) && !fp_rdy) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_grant_cnt = grant_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_toy_fp_issue_arb.sv
// Scoreboard bench for toy_fp_issue_arb: grants are pushed as expected issues and popped when the FP side fires.
module tb_toy_fp_issue_arb;

    localparam int NUM_REQ   = 2;
    localparam int PLD_W     = 16;
    localparam int FP_STAGES = 4;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_vld;
    logic [NUM_REQ*PLD_W-1:0] req_pld;
    logic [NUM_REQ-1:0]       req_rdy;
    logic                     flush;
    logic                     fp_vld;
    logic [PLD_W-1:0]         fp_pld;
    logic                     fp_rdy;
    logic [0:0]               fp_grant_id;
    logic                     fp_busy;

    toy_fp_issue_arb #(.NUM_REQ(NUM_REQ), .PLD_W(PLD_W), .FP_STAGES(FP_STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_pld(req_pld), .req_rdy(req_rdy),
        .flush(flush), .fp_vld(fp_vld), .fp_pld(fp_pld), .fp_rdy(fp_rdy),
        .fp_grant_id(fp_grant_id), .fp_busy(fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             id;
        logic [PLD_W-1:0] pld;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference state
    int   m_ptr;
    logic m_hold;
    int   m_busy;

    task automatic model_reset();
        m_ptr  = NUM_REQ - 1;
        m_hold = 1'b0;
        m_busy = 0;
        exp_q.delete();
    endtask

    // One clock: drive at negedge, compare at negedge+1, reference advances for the coming posedge.
    task automatic step(input logic [1:0] vld, input logic [PLD_W-1:0] p0, input logic [PLD_W-1:0] p1,
                        input logic rdy, input logic fl);
        logic       take;
        logic       fire;
        int         win;
        int         idx;
        logic [1:0] exp_rdy;
        exp_t       e;
        @(negedge clk);
        req_vld = vld;
        req_pld = {p1, p0};
        fp_rdy  = rdy;
        flush   = fl;
        #1;
        take = (!m_hold || rdy) && !fl;
        win  = -1;
        if (take) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (win < 0 && vld[idx]) win = idx;
            end
        end
        exp_rdy = (win >= 0) ? (2'b01 << win) : 2'b00;
        n_checks++;
        if (req_rdy !== exp_rdy) $display("FAIL req_rdy: got %b want %b", req_rdy, exp_rdy);
        else n_pass++;
        n_checks++;
        if (fp_vld !== m_hold) $display("FAIL fp_vld: got %b want %b", fp_vld, m_hold);
        else n_pass++;
        n_checks++;
        if (fp_busy !== (m_busy != 0)) $display("FAIL fp_busy: got %b want %b", fp_busy, (m_busy != 0));
        else n_pass++;
        fire = m_hold && rdy;
        if (fire) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL issue_underflow: got fire with id %0d want no issue", fp_grant_id);
            end else begin
                e = exp_q.pop_front();
                if (fp_grant_id !== e.id || fp_pld !== e.pld)
                    $display("FAIL issue: got id %0d pld %h want id %0d pld %h", fp_grant_id, fp_pld, e.id, e.pld);
                else n_pass++;
            end
        end else if (m_hold && fl && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
        if (win >= 0) begin
            e.id  = win[0];
            e.pld = (win == 1) ? p1 : p0;
            exp_q.push_back(e);
            m_ptr  = win;
            m_hold = 1'b1;
        end else if (fire || fl) begin
            m_hold = 1'b0;
        end
        if (fire) m_busy = FP_STAGES + 2;
        else if (m_busy != 0) m_busy--;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (m_hold || m_busy != 0); i++) step(2'b00, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_vld = '0; req_pld = '0; fp_rdy = 1'b0; flush = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({req_rdy, fp_vld, fp_busy, fp_grant_id, fp_pld} !== '0)
            $display("FAIL reset_init: got rdy %b vld %b busy %b id %0d pld %h want all 0",
                     req_rdy, fp_vld, fp_busy, fp_grant_id, fp_pld);
        else n_pass++;
        rst_n = 1'b1;
        step(2'b01, 16'h1111, 16'h2222, 1'b0, 1'b0);
        step(2'b00, '0, '0, 1'b1, 1'b0);
        step(2'b10, 16'h3333, 16'h4444, 1'b0, 1'b0);
        // Assert reset mid-cycle while holding, busy, and with a request pending.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (fp_vld !== 1'b0 || req_rdy !== 2'b00 || fp_busy !== 1'b0)
            $display("FAIL reset_async: got vld %b rdy %b busy %b want 0 0 0", fp_vld, req_rdy, fp_busy);
        else n_pass++;
        req_vld = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b11, 16'h0A0A, 16'h0B0B, 1'b0, 1'b0);
        n_checks++;
        if (m_ptr != 0) $display("FAIL reset_first_grant: got %0d want 0", m_ptr);
        else n_pass++;
        drain();
    endtask

    task automatic test_round_robin();
        int ids[4];
        step(2'b11, 16'h0100, 16'h0101, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 16'h0200 + 16'(i), 16'h0300 + 16'(i), 1'b1, 1'b0);
            ids[i] = fp_grant_id;
        end
        n_checks++;
        if (ids[0] == ids[1] || ids[1] == ids[2] || ids[2] == ids[3])
            $display("FAIL round_robin_alternate: got %0d %0d %0d %0d want alternating",
                     ids[0], ids[1], ids[2], ids[3]);
        else n_pass++;
        drain();
    endtask

    task automatic test_stall();
        step(2'b10, 16'h0000, 16'h00A5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(2'b11, 16'h5555, 16'h6666, 1'b0, 1'b0);
            n_checks++;
            if (fp_pld !== 16'h00A5 || fp_grant_id !== 1'b1)
                $display("FAIL stall_hold: got pld %h id %0d want pld 00a5 id 1", fp_pld, fp_grant_id);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_flush();
        step(2'b11, 16'h0F00, 16'h0F01, 1'b1, 1'b0);
        step(2'b11, '0, '0, 1'b0, 1'b1);
        step(2'b00, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (fp_vld !== 1'b0) $display("FAIL flush_idle: got fp_vld %b want 0", fp_vld);
        else n_pass++;
        step(2'b11, 16'h0E00, 16'h0E01, 1'b0, 1'b0);
        step(2'b11, '0, '0, 1'b1, 1'b1);
        step(2'b00, '0, '0, 1'b0, 1'b0);
        n_checks++;
        if (m_busy != FP_STAGES + 1 || fp_busy !== 1'b1)
            $display("FAIL flush_fire_busy: got fp_busy %b want 1", fp_busy);
        else n_pass++;
        drain();
    endtask

    task automatic test_busy_window();
        step(2'b01, 16'hB000, '0, 1'b0, 1'b0);
        step(2'b00, '0, '0, 1'b1, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step(2'b00, '0, '0, 1'b0, 1'b0);
            n_checks++;
            if (fp_busy !== (i <= FP_STAGES + 2))
                $display("FAIL busy_window_%0d: got %b want %b", i, fp_busy, (i <= FP_STAGES + 2));
            else n_pass++;
        end
    endtask

    task automatic test_single();
        step(2'b10, '0, 16'hC001, 1'b1, 1'b0);
        step(2'b10, '0, 16'hC002, 1'b1, 1'b0);
        n_checks++;
        if (req_rdy !== 2'b10) $display("FAIL single_regrant: got %b want 10", req_rdy);
        else n_pass++;
        drain();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall();
        test_flush();
        test_busy_window();
        test_single();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
